// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// Included by the grant selector and the top level.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Grant decision for the two memory requesters: fixed priority to A, with a
// saturating starvation counter that hands B the next cycle after MAX_WAIT A grants.
module dmem_arb_sel
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic b_req,
  output logic a_win,
  output logic b_win
);

  // At least one bit, so MAX_WAIT = 0 still elaborates (counter then stays 0).
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          w_sat;

  assign w_sat = (r_wait_cnt == CW'(MAX_WAIT));

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign b_win = rst_n & b_req & (~a_req | w_sat);
  assign a_win = rst_n & a_req & ~b_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (b_req && a_win) begin
      if (!w_sat) r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between port A (load/store unit) and
// port B (loader/debug): one access per cycle, read data returned one cycle after grant.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  logic              w_a_win;
  logic              w_b_win;
  logic              w_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  logic              r_rd_pend;
  owner_e            r_rd_own;

  dmem_arb_sel #(
    .MAX_WAIT (MAX_WAIT)
  ) u_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .a_req (a_req),
    .b_req (b_req),
    .a_win (w_a_win),
    .b_win (w_b_win)
  );

  assign w_any = w_a_win | w_b_win;

  // Winner mux; with no winner every field falls back to 0.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    if (w_b_win) begin
      w_we    = b_we;
      w_addr  = b_addr;
      w_wdata = b_wdata;
    end else if (w_a_win) begin
      w_we    = a_we;
      w_addr  = a_addr;
      w_wdata = a_wdata;
    end
  end

  assign a_gnt            = w_a_win;
  assign b_gnt            = w_b_win;
  assign mem_write_enable = w_any & w_we;
  assign mem_read_enable  = w_any & ~w_we;
  assign mem_address      = {{(32-ADDR_W){1'b0}}, w_addr};
  assign mem_write_data   = w_wdata;

  // One-deep read tag: the memory returns data the cycle after the grant,
  // so a new grant may overlap the returning read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_rd_own  <= OWN_A;
    end else begin
      r_rd_pend <= w_any & ~w_we;
      r_rd_own  <= w_b_win ? OWN_B : OWN_A;
    end
  end

  assign a_rvalid = r_rd_pend & (r_rd_own == OWN_A);
  assign b_rvalid = r_rd_pend & (r_rd_own == OWN_B);
  assign a_rdata  = a_rvalid ? mem_read_data : '0;
  assign b_rdata  = b_rvalid ? mem_read_data : '0;

endmodule
